// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one command-driven memory between two
//            requesters, granting whole two-word transactions and routing read
//            data back to the owner. Optional abort counter: MEM_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================

module mem_arbiter_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [9:0] din,
  output logic [9:0] head,
  output logic       not_empty,
  output logic       ovf
);
  logic [9:0] r_e0;
  logic [9:0] r_e1;
  logic [1:0] r_cnt;
  logic       r_ovf;

  // Entry 0 is always the head; pop shifts entry 1 down
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (pop && push) begin
      if (r_cnt == 2'd2) begin
        r_e0 <= r_e1;
        r_e1 <= din;
      end else begin
        r_e0 <= din;
      end
    end else if (pop) begin
      r_e0  <= r_e1;
      r_cnt <= r_cnt - 2'd1;
    end else if (push) begin
      if (r_cnt == 2'd2) begin
        r_ovf <= 1'b1;
      end else begin
        if (r_cnt == 2'd0) r_e0 <= din;
        else               r_e1 <= din;
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  assign head      = r_e0;
  assign not_empty = (r_cnt != 2'd0);
  assign ovf       = r_ovf;
endmodule

module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] req0_data,
  input  logic       req0_valid,
  input  logic [9:0] req1_data,
  input  logic       req1_valid,
  output logic [7:0] rsp0_data,
  output logic       rsp0_valid,
  output logic       rsp0_err,
  output logic [7:0] rsp1_data,
  output logic       rsp1_valid,
  output logic       rsp1_err,
  output logic       ovf0,
  output logic       ovf1,
  output logic [9:0] mem_din,
  output logic       mem_rx_valid,
  input  logic [7:0] mem_dout,
  input  logic       mem_tx_valid
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    RDWAIT = 2'd3
  } state_t;

  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("mem_arbiter: TIMEOUT must be at least 2");
  end

  state_t     r_state, w_state_n;
  logic       r_gnt, w_gnt_n;
  logic       r_rr, w_rr_n;
  logic [1:0] r_cmd, w_cmd_n;
  logic       r_settle, w_settle_n;
  logic [9:0] r_mem_din;
  logic       r_mem_rx_valid;
  logic [7:0] r_rsp_data0, r_rsp_data1;
  logic [1:0] r_rsp_valid, r_rsp_err;

  logic [1:0] w_pop;
  logic [1:0] w_ne;
  logic [9:0] w_head0, w_head1, w_head;
  logic       w_issue, w_err, w_rsp, w_tmo_hit;
  logic [7:0] w_rsp_data;

  mem_arbiter_fifo u_fifo0 (
    .clk(clk), .rst(rst), .push(req0_valid), .pop(w_pop[0]), .din(req0_data),
    .head(w_head0), .not_empty(w_ne[0]), .ovf(ovf0)
  );

  mem_arbiter_fifo u_fifo1 (
    .clk(clk), .rst(rst), .push(req1_valid), .pop(w_pop[1]), .din(req1_data),
    .head(w_head1), .not_empty(w_ne[1]), .ovf(ovf1)
  );

  assign w_head = r_gnt ? w_head1 : w_head0;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int c_tmo_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
  logic [c_tmo_w-1:0] r_tmo;

  // Restarts on every state change, so it counts cycles spent in the current state
  always_ff @(posedge clk) begin
    if (rst || (w_state_n != r_state)) r_tmo <= '0;
    else                               r_tmo <= r_tmo + c_tmo_w'(1);
  end

  assign w_tmo_hit = ((r_state == SECOND) || (r_state == RDWAIT)) && (r_tmo == c_tmo_last);
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_n  = r_state;
    w_gnt_n    = r_gnt;
    w_rr_n     = r_rr;
    w_cmd_n    = r_cmd;
    w_settle_n = 1'b0;
    w_pop      = 2'b00;
    w_issue    = 1'b0;
    w_err      = 1'b0;
    w_rsp      = 1'b0;
    w_rsp_data = mem_dout;
    case (r_state)
      IDLE: begin
        if (w_ne != 2'b00) begin
          w_state_n = FIRST;
          if (w_ne == 2'b11) begin
            w_gnt_n = r_rr;
            w_rr_n  = ~r_rr;
          end else begin
            w_gnt_n = w_ne[1];
          end
        end
      end
      FIRST: begin
        w_pop[r_gnt] = 1'b1;
        if (!w_head[8]) begin
          w_issue    = 1'b1;
          w_cmd_n    = w_head[9:8];
          w_settle_n = 1'b1;
          w_state_n  = SECOND;
        end else begin
          w_err     = 1'b1;
          w_state_n = IDLE;
        end
      end
      SECOND: begin
        // One settle cycle keeps the two command strobes of a transaction apart
        if (!r_settle && w_ne[r_gnt]) begin
          if (w_head[9:8] == r_cmd + 2'd1) begin
            w_issue      = 1'b1;
            w_pop[r_gnt] = 1'b1;
            w_state_n    = r_cmd[1] ? RDWAIT : IDLE;
          end else begin
            w_err     = 1'b1;
            w_state_n = IDLE;
          end
        end else if (w_tmo_hit) begin
          w_err     = 1'b1;
          w_state_n = IDLE;
        end
      end
      RDWAIT: begin
        if (mem_tx_valid) begin
          w_rsp     = 1'b1;
          w_state_n = IDLE;
        end else if (w_tmo_hit) begin
          w_rsp      = 1'b1;
          w_err      = 1'b1;
          w_rsp_data = 8'h00;
          w_state_n  = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_gnt          <= 1'b0;
      r_rr           <= 1'b0;
      r_cmd          <= 2'b00;
      r_settle       <= 1'b0;
      r_mem_din      <= '0;
      r_mem_rx_valid <= 1'b0;
      r_rsp_data0    <= '0;
      r_rsp_data1    <= '0;
      r_rsp_valid    <= 2'b00;
      r_rsp_err      <= 2'b00;
    end else begin
      r_state        <= w_state_n;
      r_gnt          <= w_gnt_n;
      r_rr           <= w_rr_n;
      r_cmd          <= w_cmd_n;
      r_settle       <= w_settle_n;
      r_mem_rx_valid <= w_issue;
      if (w_issue) r_mem_din <= w_head;
      r_rsp_valid    <= w_rsp ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
      r_rsp_err      <= w_err ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
      if (w_rsp && !r_gnt) r_rsp_data0 <= w_rsp_data;
      if (w_rsp &&  r_gnt) r_rsp_data1 <= w_rsp_data;
    end
  end

  assign mem_din      = r_mem_din;
  assign mem_rx_valid = r_mem_rx_valid;
  assign rsp0_data    = r_rsp_data0;
  assign rsp1_data    = r_rsp_data1;
  assign rsp0_valid   = r_rsp_valid[0];
  assign rsp1_valid   = r_rsp_valid[1];
  assign rsp0_err     = r_rsp_err[0];
  assign rsp1_err     = r_rsp_err[1];
endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed and randomized bench for mem_arbiter against a
//            queue-based transaction model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;
  localparam int TMO = 16;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] req0_data = '0, req1_data = '0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, ovf0, ovf1;
  logic [9:0] mem_din;
  logic       mem_rx_valid;
  logic [7:0] mem_dout = '0;
  logic       mem_tx_valid = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid),
    .req1_data(req1_data), .req1_valid(req1_valid),
    .rsp0_data(rsp0_data), .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err),
    .rsp1_data(rsp1_data), .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
    .ovf0(ovf0), .ovf1(ovf1),
    .mem_din(mem_din), .mem_rx_valid(mem_rx_valid),
    .mem_dout(mem_dout), .mem_tx_valid(mem_tx_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  logic [9:0] mq0[$];
  logic [9:0] mq1[$];
  int  own = -1;       // port owning the memory, -1 when free
  int  want = -1;      // data cmd expected next, -1 while the first word is pending
  bit  rd = 1'b0;      // waiting for read data
  int  ready_at = 0;
  int  deadline = 0;
  int  rr = 0;
  int  cyc = 0;
  bit  model_live = 1'b0;
  logic [9:0] e_din = '0;
  logic       e_rxv = 1'b0;
  logic [7:0] e_rdata0 = '0, e_rdata1 = '0;
  logic       e_rv0 = 1'b0, e_rv1 = 1'b0, e_err0 = 1'b0, e_err1 = 1'b0;
  logic       e_ovf0 = 1'b0, e_ovf1 = 1'b0;

  function automatic int size_of(input int p);
    return (p == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [9:0] head_of(input int p);
    return (p == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic pop_of(input int p);
    if (p == 0) void'(mq0.pop_front());
    else        void'(mq1.pop_front());
  endtask

  task automatic issue(input logic [9:0] w);
    e_rxv = 1'b1;
    e_din = w;
  endtask

  task automatic flag_err(input int p);
    if (p == 0) e_err0 = 1'b1;
    else        e_err1 = 1'b1;
  endtask

  task automatic respond(input int p, input logic [7:0] d);
    if (p == 0) begin e_rv0 = 1'b1; e_rdata0 = d; end
    else        begin e_rv1 = 1'b1; e_rdata1 = d; end
  endtask

  always @(posedge clk) begin
    logic [9:0] h;
    e_rxv = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
    if (rst) begin
      mq0.delete(); mq1.delete();
      own = -1; want = -1; rd = 1'b0; rr = 0;
      e_din = '0; e_rdata0 = '0; e_rdata1 = '0; e_ovf0 = 1'b0; e_ovf1 = 1'b0;
      model_live = 1'b1;
    end else begin
      if (own < 0) begin
        if (mq0.size() > 0 && mq1.size() > 0) begin own = rr; rr = 1 - rr; end
        else if (mq0.size() > 0) own = 0;
        else if (mq1.size() > 0) own = 1;
        want = -1; rd = 1'b0;
      end else if (want < 0) begin
        h = head_of(own);
        pop_of(own);
        if (h[8] == 1'b0) begin
          issue(h);
          want = int'(h[9:8]) + 1;
          ready_at = cyc + 2;
          deadline = cyc + TMO;
        end else begin
          flag_err(own); own = -1;
        end
      end else if (rd) begin
        if (mem_tx_valid) begin respond(own, mem_dout); own = -1; end
        else if (TMO_ON && cyc == deadline) begin
          respond(own, 8'h00); flag_err(own); own = -1;
        end
      end else begin
        if (cyc >= ready_at && size_of(own) > 0) begin
          h = head_of(own);
          if (h[9:8] == want[1:0]) begin
            issue(h); pop_of(own);
            if (want == 1) own = -1;
            else begin rd = 1'b1; deadline = cyc + TMO; end
          end else begin
            flag_err(own); own = -1;
          end
        end else if (TMO_ON && cyc == deadline) begin
          flag_err(own); own = -1;
        end
      end
      if (req0_valid) begin if (mq0.size() < 2) mq0.push_back(req0_data); else e_ovf0 = 1'b1; end
      if (req1_valid) begin if (mq1.size() < 2) mq1.push_back(req1_data); else e_ovf1 = 1'b1; end
    end
    cyc++;
  end

  // ---------------- per-cycle comparison ----------------
  logic [9:0] mem_log[$];

  always @(negedge clk) begin
    if (model_live) begin
      chk("cycle_outputs",
          {mem_rx_valid, mem_din, rsp0_valid, rsp0_err, rsp0_data,
           rsp1_valid, rsp1_err, rsp1_data, ovf0, ovf1},
          {e_rxv, e_din, e_rv0, e_err0, e_rdata0,
           e_rv1, e_err1, e_rdata1, e_ovf0, e_ovf1});
      if (mem_rx_valid) mem_log.push_back(mem_din);
    end
  end

  // ---------------- stimulus ----------------
  int         ph[2];
  logic [1:0] lc[2];

  function automatic logic [9:0] gen_word(input int p);
    logic [1:0] c;
    if ($urandom_range(0, 9) == 0)   c = 2'($urandom_range(0, 3));
    else if (ph[p] == 0)              c = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
    else                              c = lc[p] + 2'd1;
    ph[p] = (c[0] == 1'b0) ? 1 : 0;
    lc[p] = c;
    return {c, 8'($urandom_range(0, 255))};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [9:0] d0, input logic v1, input logic [9:0] d1);
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; mem_tx_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mem_log.delete();
  endtask

  initial begin
    ph[0] = 0; ph[1] = 0; lc[0] = 2'b00; lc[1] = 2'b00;

    // reset state
    do_reset();
    chk("reset_outputs",
        {mem_rx_valid, mem_din, rsp0_valid, rsp0_err, rsp0_data,
         rsp1_valid, rsp1_err, rsp1_data, ovf0, ovf1}, 64'd0);

    // write on port 1
    drive(1'b0, 10'h000, 1'b1, 10'h012);
    drive(1'b0, 10'h000, 1'b1, 10'h1A5);
    tick();
    chk("write_word1_c3", {mem_rx_valid, mem_din}, {1'b1, 10'h012});
    tick();
    chk("write_gap_c4", mem_rx_valid, 1'b0);
    tick();
    chk("write_word2_c5", {mem_rx_valid, mem_din}, {1'b1, 10'h1A5});

    // read on port 0
    do_reset();
    drive(1'b1, 10'h212, 1'b0, 10'h000);
    drive(1'b1, 10'h300, 1'b0, 10'h000);
    tick();
    chk("read_addr_c3", {mem_rx_valid, mem_din}, {1'b1, 10'h212});
    tick(); tick();
    chk("read_cmd_c5", {mem_rx_valid, mem_din}, {1'b1, 10'h300});
    tick(); tick();
    mem_dout = 8'hA5; mem_tx_valid = 1'b1;
    tick();
    mem_tx_valid = 1'b0;
    chk("read_rsp", {rsp0_valid, rsp0_err, rsp0_data, rsp1_valid}, {1'b1, 1'b0, 8'hA5, 1'b0});
    tick();
    chk("read_rsp_pulse", rsp0_valid, 1'b0);

    // contention twice: port 0 first, then port 1 first
    do_reset();
    drive(1'b1, 10'h011, 1'b1, 10'h022);
    drive(1'b1, 10'h1AA, 1'b1, 10'h1BB);
    repeat (10) tick();
    chk("contend_a_count", mem_log.size(), 4);
    chk("contend_a_order", {mem_log[0], mem_log[1], mem_log[2], mem_log[3]},
        {10'h011, 10'h1AA, 10'h022, 10'h1BB});
    mem_log.delete();
    drive(1'b1, 10'h011, 1'b1, 10'h022);
    drive(1'b1, 10'h1AA, 1'b1, 10'h1BB);
    repeat (10) tick();
    chk("contend_b_count", mem_log.size(), 4);
    chk("contend_b_order", {mem_log[0], mem_log[1], mem_log[2], mem_log[3]},
        {10'h022, 10'h1BB, 10'h011, 10'h1AA});

    // protocol errors
    do_reset();
    drive(1'b1, 10'h1FF, 1'b0, 10'h000);
    tick(); tick();
    chk("err_data_first", {rsp0_err, rsp1_err, mem_rx_valid}, 3'b100);
    tick();
    chk("err_pulse", rsp0_err, 1'b0);
    do_reset();
    drive(1'b1, 10'h020, 1'b0, 10'h000);
    drive(1'b1, 10'h230, 1'b0, 10'h000);
    tick();
    chk("err_first_issued", {mem_rx_valid, mem_din}, {1'b1, 10'h020});
    tick(); tick();
    chk("err_bad_second", {rsp0_err, mem_rx_valid}, 2'b10);
    tick(); tick();
    chk("err_retained_word", {mem_rx_valid, mem_din}, {1'b1, 10'h230});

    // overflow on port 1 while port 0 holds the grant
    do_reset();
    drive(1'b1, 10'h011, 1'b0, 10'h000);
    drive(1'b0, 10'h000, 1'b1, 10'h033);
    drive(1'b0, 10'h000, 1'b1, 10'h144);
    chk("ovf_before", {ovf1, ovf0}, 2'b00);
    drive(1'b0, 10'h000, 1'b1, 10'h155);
    chk("ovf_set", {ovf1, ovf0}, 2'b10);
    drive(1'b1, 10'h1AA, 1'b0, 10'h000);
    repeat (8) tick();
    chk("ovf_order", {mem_log[0], mem_log[1], mem_log[2], mem_log[3]},
        {10'h011, 10'h1AA, 10'h033, 10'h144});
    chk("ovf_sticky", ovf1, 1'b1);
    do_reset();
    chk("ovf_cleared", ovf1, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    // read that never gets data: abort 16 cycles after entering RDWAIT
    do_reset();
    drive(1'b1, 10'h212, 1'b0, 10'h000);
    drive(1'b1, 10'h300, 1'b0, 10'h000);
    repeat (18) tick();
    chk("tmo_not_yet", rsp0_valid, 1'b0);
    tick();
    chk("tmo_abort", {rsp0_valid, rsp0_err, rsp0_data}, {1'b1, 1'b1, 8'h00});
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 499) == 0);
      req0_valid   = ($urandom_range(0, 9) < 4);
      req0_data    = req0_valid ? gen_word(0) : 10'h000;
      req1_valid   = ($urandom_range(0, 9) < 4);
      req1_data    = req1_valid ? gen_word(1) : 10'h000;
      mem_tx_valid = ($urandom_range(0, 3) == 0);
      mem_dout     = 8'($urandom_range(0, 255));
      tick();
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; mem_tx_valid = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
